id_issue_queue: RTL and testbench
=================================

ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

Interface
REQ-001 Parameter: DEPTH, 4, entry count; power of two, 2..16.
REQ-002 Parameter: XLEN, 32, PC width.
REQ-003 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: enq_valid  in  1  fetch presents an instruction.
REQ-006 Port: enq_pc  in  XLEN  PC of enqueued instruction.
REQ-007 Port: enq_instr  in  32  raw instruction word.
REQ-008 Port: enq_ready  out  1  queue accepts this cycle.
REQ-009 Port: deq_valid  out  1  head instruction issuable.
REQ-010 Port: deq_ready  in  1  decode/ID-EX accepts head.
REQ-011 Port: deq_pc  out  XLEN  head PC.
REQ-012 Port: deq_instr  out  32  head instruction word.
REQ-013 Port: deq_rs1, deq_rs2, deq_rd  out  5 each  head instr[19:15], [24:20], [11:7].
REQ-014 Port: flush  in  1  branch taken; squash all queued entries.
REQ-015 Port: wb_load  in  1  a load writes back this cycle.
REQ-016 Port: wb_rd  in  5  destination of that load.
REQ-017 Port: count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-018 Circular FIFO with head/tail pointers wrapping at DEPTH and a count register; enqueue occurs when enq_valid and enq_ready, dequeue when deq_valid and deq_ready.
REQ-019 enq_ready SHALL be 1 exactly when count < DEPTH; no pass-through when full, even if a dequeue occurs that cycle.
REQ-020 Minimum latency is 1 cycle: an entry enqueued at edge N is visible at head no earlier than cycle after edge N; no empty-queue bypass.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-022 Scoreboard: 32-bit busy vector; on dequeue of opcode 0000011 (LOAD) with rd != 0, busy[rd] is set at that edge.
REQ-023 busy[wb_rd] SHALL clear at the edge where wb_load is 1; set and clear of the same register in one cycle: set wins.
REQ-024 Head uses rs1 unless opcode is LUI, AUIPC or JAL; uses rs2 only for OP, STORE, BRANCH; register x0 is never busy.
REQ-025 deq_valid SHALL be 1 only when count != 0, flush is 0, and no used source register is busy.
REQ-026 flush SHALL zero count and reset both pointers at the edge; any same-cycle enqueue is discarded and deq_valid is 0 that cycle.
REQ-027 flush SHALL NOT clear the scoreboard; downstream guarantees wb_load for every dequeued load, squashed loads included.
REQ-028 deq_* data outputs reflect head storage regardless of deq_valid.

Reset
REQ-029 At the reset edge: count 0, pointers 0, busy vector 0, storage 0; thereafter deq_valid 0, enq_ready 1, deq_pc/deq_instr 0.
REQ-030 rst dominates flush, enqueue, dequeue and wb_load in the same cycle; a reset mid-stall discards all entries.

Configuration
REQ-031 Macro ID_SB_BYPASS_EN defined: a wb_load matching a busy source in the current cycle unblocks deq_valid combinationally that same cycle.
REQ-032 Macro ID_SB_BYPASS_EN undefined: deq_valid stays 0 until the cycle after the clearing edge (one extra stall cycle).

Verification
REQ-033 Fill: 5 enqueues with DEPTH=4, deq_ready=0 -> count=4, enq_ready=0, 5th not accepted; drain returns PCs in order.
REQ-034 Load-use: dequeue lw x5, next head add x6,x5,x1 -> deq_valid 0 until wb_load=1, wb_rd=5; released same cycle with macro, next cycle without.
REQ-035 x0 load: dequeue lw x0, next head uses x0 -> no stall, deq_valid 1 immediately.
REQ-036 Flush with enq_valid=1, count=3 -> count=0 next cycle, enqueued word absent, busy bits from earlier load retained.
REQ-037 Wrap: 10 enqueue/dequeue pairs at full throughput with DEPTH=4 -> order preserved across pointer wrap, count constant.
REQ-038 Reset with count=2 and busy[7]=1 -> count 0, busy clear, deq_valid 0, enq_ready 1.

Source files
------------

// File: rtl/id_issue_queue.sv
// ---------------------------------------------------------------------------
// id_issue_queue
//   Decode-stage instruction queue with a load-use scoreboard. Fetch pushes
//   (pc, instr) pairs into a circular buffer; the head is offered to decode
//   only when none of the source registers it actually reads is waiting on an
//   outstanding load. Loads mark their rd busy when they leave the queue and
//   the write-back port clears the bit again.
//
//   Optional feature macro: ID_SB_BYPASS_EN
//     defined   -> a write-back in the current cycle releases a stalled head
//                  combinationally in that same cycle.
//     undefined -> the head is released the cycle after the clearing edge.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   enq_valid/enq_ready      fetch handshake; enq_pc, enq_instr payload
//   deq_valid/deq_ready      decode handshake
//   deq_pc, deq_instr        head storage (valid or not)
//   deq_rs1/rs2/rd           register fields decoded from the head word
//   flush                    squash every queued entry
//   wb_load, wb_rd           a load writes back register wb_rd this cycle
//   count                    current occupancy
// ---------------------------------------------------------------------------
module id_issue_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic [31:0]              enq_instr,
  output logic                     enq_ready,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_pc,
  output logic [31:0]              deq_instr,
  output logic [4:0]               deq_rs1,
  output logic [4:0]               deq_rs2,
  output logic [4:0]               deq_rd,
  input  logic                     flush,
  input  logic                     wb_load,
  input  logic [4:0]               wb_rd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [XLEN-1:0]  r_mem_pc    [DEPTH];
  logic [31:0]      r_mem_instr [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_busy;

  logic [6:0]  w_opcode;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic [31:0] w_busy_eff;
  logic        w_stall;
  logic        w_enq;
  logic        w_deq;
  logic        w_head_is_load;
  logic [31:0] w_busy_nxt;

  assign deq_pc    = r_mem_pc[r_head];
  assign deq_instr = r_mem_instr[r_head];
  assign deq_rs1   = deq_instr[19:15];
  assign deq_rs2   = deq_instr[24:20];
  assign deq_rd    = deq_instr[11:7];
  assign w_opcode  = deq_instr[6:0];
  assign count     = r_count;

  // Which source fields the head really reads; unused fields may hold
  // immediate bits and must not cause false stalls.
  assign w_use_rs1 = !((w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) ||
                       (w_opcode == OPC_JAL));
  assign w_use_rs2 = (w_opcode == OPC_OP) || (w_opcode == OPC_STORE) ||
                     (w_opcode == OPC_BRANCH);

`ifdef ID_SB_BYPASS_EN
  // Same-cycle write-back hides the busy bit from the hazard check.
  assign w_busy_eff = r_busy & ~(wb_load ? (32'd1 << wb_rd) : 32'd0);
`else
  assign w_busy_eff = r_busy;
`endif

  assign w_stall = (w_use_rs1 && (deq_rs1 != 5'd0) && w_busy_eff[deq_rs1]) ||
                   (w_use_rs2 && (deq_rs2 != 5'd0) && w_busy_eff[deq_rs2]);

  assign enq_ready      = (r_count < CNT_W'(DEPTH));
  assign deq_valid      = (r_count != '0) && !flush && !w_stall;
  assign w_enq          = enq_valid && enq_ready;
  assign w_deq          = deq_valid && deq_ready;
  assign w_head_is_load = (w_opcode == OPC_LOAD) && (deq_rd != 5'd0);

  // Clear first, then set, so a load leaving the queue wins over a
  // write-back to the same register in the same cycle.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_load)
      w_busy_nxt[wb_rd] = 1'b0;
    if (w_deq && w_head_is_load)
      w_busy_nxt[deq_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
    end else begin
      // The scoreboard survives a flush: squashed loads still write back.
      r_busy <= w_busy_nxt;
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_enq) begin
          r_mem_pc[r_tail]    <= enq_pc;
          r_mem_instr[r_tail] <= enq_instr;
          r_tail              <= r_tail + PTR_W'(1);
        end
        if (w_deq)
          r_head <= r_head + PTR_W'(1);
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_issue_queue.sv
module tb_id_issue_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enq_valid;
  logic [XLEN-1:0]       enq_pc;
  logic [31:0]           enq_instr;
  logic                  enq_ready;
  logic                  deq_valid;
  logic                  deq_ready;
  logic [XLEN-1:0]       deq_pc;
  logic [31:0]           deq_instr;
  logic [4:0]            deq_rs1, deq_rs2, deq_rd;
  logic                  flush;
  logic                  wb_load;
  logic [4:0]            wb_rd;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mbusy = '0;

  always #5 clk = ~clk;

  id_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_instr(enq_instr),
    .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_instr(deq_instr),
    .deq_rs1(deq_rs1), .deq_rs2(deq_rs2), .deq_rd(deq_rd),
    .flush(flush), .wb_load(wb_load), .wb_rd(wb_rd), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic blocked(input logic [31:0] ins, input logic [31:0] bz);
    logic [6:0] op;
    logic       u1, u2;
    op = ins[6:0];
    u1 = !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
    u2 = (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
    return (u1 && ins[19:15] != 5'd0 && bz[ins[19:15]]) ||
           (u2 && ins[24:20] != 5'd0 && bz[ins[24:20]]);
  endfunction

  function automatic logic exp_dv();
    logic [31:0] bz;
    if (mq.size() == 0 || flush) return 1'b0;
    bz = mbusy;
`ifdef ID_SB_BYPASS_EN
    if (wb_load) bz[wb_rd] = 1'b0;
`endif
    return !blocked(mq[0].instr, bz);
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, OPC_LOAD};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] ins;
    ops = '{OPC_LOAD, OPC_OP, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC,
            OPC_JAL, 7'b0010011, 7'b1100111};
    ins        = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 8)];
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    ins[11:7]  = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  task automatic idle();
    rst = 1'b0; enq_valid = 1'b0; enq_pc = '0; enq_instr = '0;
    deq_ready = 1'b0; flush = 1'b0; wb_load = 1'b0; wb_rd = '0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    enq_valid = 1'b1; enq_pc = pc; enq_instr = ins;
  endtask

  // Compare outputs against the reference model on the falling edge.
  task automatic sample();
    @(negedge clk);
    chk("count", 64'(count), 64'(mq.size()));
    chk("enq_ready", 64'(enq_ready), 64'(mq.size() < DEPTH));
    chk("deq_valid", 64'(deq_valid), 64'(exp_dv()));
    if (mq.size() > 0) begin
      chk("deq_pc", 64'(deq_pc), 64'(mq[0].pc));
      chk("deq_instr", 64'(deq_instr), 64'(mq[0].instr));
      chk("deq_rs1", 64'(deq_rs1), 64'(mq[0].instr[19:15]));
      chk("deq_rs2", 64'(deq_rs2), 64'(mq[0].instr[24:20]));
      chk("deq_rd", 64'(deq_rd), 64'(mq[0].instr[11:7]));
    end
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    logic e_dv, e_enq, e_deq;
    ent_t h;
    e_dv  = exp_dv();
    e_enq = enq_valid && (mq.size() < DEPTH);
    e_deq = e_dv && deq_ready;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mbusy = '0;
    end else begin
      if (wb_load) mbusy[wb_rd] = 1'b0;
      if (flush) mq.delete();
      else begin
        if (e_deq) begin
          h = mq.pop_front();
          if (h.instr[6:0] == OPC_LOAD && h.instr[11:7] != 5'd0)
            mbusy[h.instr[11:7]] = 1'b1;
        end
        if (e_enq) mq.push_back('{pc: enq_pc, instr: enq_instr});
      end
    end
    #1;
  endtask

  initial begin
    // reset
    idle(); rst = 1'b1;
    tick(); tick();
    idle();
    sample();
    chk("rst_deq_pc", 64'(deq_pc), 64'd0);
    chk("rst_deq_instr", 64'(deq_instr), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    tick();

    // fill with 5 enqueues while decode is stalled
    for (int i = 0; i < 5; i++) begin
      idle(); push(32'h100 + 32'(4 * i), NOP);
      sample();
      if (i == 4) chk("fill_5th_not_ready", 64'(enq_ready), 64'd0);
      tick();
    end
    idle();
    sample();
    chk("fill_count", 64'(count), 64'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(); deq_ready = 1'b1;
      sample();
      chk("drain_pc", 64'(deq_pc), 64'(32'h100 + 32'(4 * i)));
      tick();
    end

    // load-use: lw x5 then add x6,x5,x1
    idle(); push(32'h200, lw(5'd5, 5'd1)); sample(); tick();
    idle(); push(32'h204, add(5'd6, 5'd5, 5'd1)); sample(); tick();
    idle(); deq_ready = 1'b1; sample();
    chk("lu_lw_valid", 64'(deq_valid), 64'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle(); deq_ready = 1'b1; sample();
      chk("lu_stall", 64'(deq_valid), 64'd0);
      tick();
    end
    idle(); deq_ready = 1'b1; wb_load = 1'b1; wb_rd = 5'd5; sample();
`ifdef ID_SB_BYPASS_EN
    chk("lu_wb_cycle", 64'(deq_valid), 64'd1);
`else
    chk("lu_wb_cycle", 64'(deq_valid), 64'd0);
`endif
    tick();
    idle(); deq_ready = 1'b1;
    sample();
    tick();
    idle(); sample(); chk("lu_empty", 64'(count), 64'd0); tick();

    // load to x0 never blocks a consumer of x0
    idle(); push(32'h300, lw(5'd0, 5'd2)); sample(); tick();
    idle(); push(32'h304, add(5'd3, 5'd0, 5'd0)); sample(); tick();
    idle(); deq_ready = 1'b1; sample(); tick();
    idle(); deq_ready = 1'b1; sample();
    chk("x0_no_stall", 64'(deq_valid), 64'd1);
    tick();

    // flush with a pending load's busy bit set
    idle(); push(32'h400, lw(5'd9, 5'd0)); sample(); tick();
    idle(); deq_ready = 1'b1; sample(); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); push(32'h410 + 32'(4 * i), add(5'd1, 5'd9, 5'd0)); sample(); tick();
    end
    idle(); push(32'h4F0, NOP); flush = 1'b1; sample();
    chk("flush_count_before", 64'(count), 64'd3);
    chk("flush_dv", 64'(deq_valid), 64'd0);
    tick();
    idle(); sample(); chk("flush_count", 64'(count), 64'd0); tick();
    idle(); push(32'h420, add(5'd2, 5'd9, 5'd0)); sample(); tick();
    idle(); deq_ready = 1'b1; sample();
    chk("flush_busy_kept", 64'(deq_valid), 64'd0);
    tick();
    idle(); wb_load = 1'b1; wb_rd = 5'd9; deq_ready = 1'b1; sample(); tick();
    idle(); deq_ready = 1'b1; sample(); tick();

    // wrap at full throughput with two entries resident
    idle(); push(32'h500, NOP); sample(); tick();
    idle(); push(32'h504, NOP); sample(); tick();
    for (int i = 0; i < 10; i++) begin
      idle(); push(32'h508 + 32'(4 * i), NOP); deq_ready = 1'b1;
      sample();
      chk("wrap_count", 64'(count), 64'd2);
      chk("wrap_pc", 64'(deq_pc), 64'(32'h500 + 32'(4 * i)));
      tick();
    end

    // reset mid-stall with busy[7] set
    idle(); deq_ready = 1'b1; sample(); tick();
    idle(); deq_ready = 1'b1; sample(); tick();
    idle(); push(32'h600, lw(5'd7, 5'd0)); sample(); tick();
    idle(); deq_ready = 1'b1; sample(); tick();
    idle(); push(32'h604, add(5'd1, 5'd7, 5'd0)); sample(); tick();
    idle(); push(32'h608, NOP); sample(); tick();
    idle(); rst = 1'b1; push(32'h60C, NOP); flush = 1'b1; wb_load = 1'b1; wb_rd = 5'd3;
    deq_ready = 1'b1; sample();
    chk("mid_count_before", 64'(count), 64'd2);
    tick();
    idle(); sample();
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_dv", 64'(deq_valid), 64'd0);
    chk("mid_rst_rdy", 64'(enq_ready), 64'd1);
    tick();
    idle(); push(32'h700, add(5'd1, 5'd7, 5'd7)); sample(); tick();
    idle(); sample(); chk("mid_busy_clear", 64'(deq_valid), 64'd1); tick();

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      idle();
      enq_valid = ($urandom_range(0, 3) != 0);
      enq_pc    = $urandom;
      enq_instr = rand_instr();
      deq_ready = ($urandom_range(0, 3) != 0);
      wb_load   = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 150) == 0);
      sample();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
